// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package mult_pkg;

    localparam int unsigned MULT_PP_STEPS = 16;
    localparam int unsigned MULT_IDX_W    = 4;
    localparam int unsigned MULT_BYTE_W   = 8;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mult_seq_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? 32'(~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult32_seq_mult8u.sv
// Combinational 8x8 unsigned multiplier shared by the 32x32 sequencer.
module Mult8U (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    assign p = 16'(a) * 16'(b);

endmodule

// File: rtl/mult32_seq.sv
// 32x32 RISC-V MUL/MULH/MULHSU/MULHU sequencer: 16 byte-pair partial products
// through one Mult8U, then sign fix-up and word select.
module mult32_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    mult_seq_state_e        state_q, state_d;
    mul_op_e                op_q, op_d;
    logic [WIDTH-1:0]       mag_a_q, mag_a_d;
    logic [WIDTH-1:0]       mag_b_q, mag_b_d;
    logic                   neg_q, neg_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [MULT_IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;

    mul_op_e                req_op;
    logic                   sign_a, sign_b;
    logic [1:0]             ia, ib;
    logic [MULT_BYTE_W-1:0] byte_a, byte_b;
    logic [15:0]            pp;
    logic [5:0]             pp_shamt;
    logic [ACC_W-1:0]       pp_shifted;
    logic [ACC_W-1:0]       fix_p;

    // Operand signedness at request time; MUL treats both sides as unsigned.
    always_comb begin
        req_op = mul_op_e'(op_sel);
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (req_op)
            MULH: begin
                sign_a = operand_a[WIDTH-1];
                sign_b = operand_b[WIDTH-1];
            end
            MULHSU: sign_a = operand_a[WIDTH-1];
            default: ;
        endcase
    end

    // Byte-pair selection: idx[1:0] walks A bytes, idx[3:2] walks B bytes.
    always_comb begin
        ia         = idx_q[1:0];
        ib         = idx_q[3:2];
        byte_a     = MULT_BYTE_W'(mag_a_q >> {ia, 3'b000});
        byte_b     = MULT_BYTE_W'(mag_b_q >> {ib, 3'b000});
        pp_shamt   = {3'({1'b0, ia} + {1'b0, ib}), 3'b000};
        pp_shifted = ACC_W'(pp) << pp_shamt;
        fix_p      = neg_q ? ACC_W'(~acc_q + ACC_W'(1)) : acc_q;
    end

    Mult8U u_mult8u (
        .a (byte_a),
        .b (byte_b),
        .p (pp)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = req_op;
                    mag_a_d = sign_a ? abs32(operand_a) : operand_a;
                    mag_b_d = sign_b ? abs32(operand_b) : operand_b;
                    neg_d   = sign_a ^ sign_b;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + pp_shifted;
                idx_d = idx_q + MULT_IDX_W'(1);
                if (idx_q == MULT_IDX_W'(MULT_PP_STEPS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d    = (op_q == MUL) ? fix_p[WIDTH-1:0] : fix_p[ACC_W-1:WIDTH];
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= MUL;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Randomized and directed checks of mult32_seq against an arithmetic model.
module tb_mult32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_sel;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult32_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full-precision product of sign/zero-extended operands, then word select.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [65:0] ea, eb, pr;
        ea = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'd0, a};
        eb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'd0, b};
        pr = ea * eb;
        return (op == 2'b00) ? pr[31:0] : pr[63:32];
    endfunction

    // One transaction: accept, measure latency, stall, handshake.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic [31:0] exp;
        int lat;
        exp = model(op, a, b);
        @(negedge clk);
        check({tag, "/in_ready_pre"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        op_sel    = op;
        operand_a = a;
        operand_b = b;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        op_sel    = 2'($urandom_range(0, 3));
        operand_a = $urandom;
        operand_b = $urandom;
        check({tag, "/in_ready_busy"}, 64'({in_ready, busy}), 64'b01);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'd17);
        check({tag, "/result"}, 64'(result), 64'(exp));
        for (int i = 0; i < stall; i++) begin
            in_valid  = 1'b1;
            op_sel    = 2'b11;
            operand_a = 32'hFFFF_FFFF;
            operand_b = 32'hFFFF_FFFF;
            @(negedge clk);
            check({tag, "/hold_state"}, 64'({out_valid, in_ready, busy}), 64'b101);
            check({tag, "/hold_result"}, 64'(result), 64'(exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/post_hs"}, 64'({in_ready, out_valid, busy}), 64'b100);
    endtask

    initial begin
        logic [31:0] pick [6];
        logic [31:0] ra, rb;
        logic [1:0]  rop;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sel    = 2'b00;
        operand_a = '0;
        operand_b = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_state", 64'({in_ready, out_valid, busy}), 64'b100);
        check("reset_result", 64'(result), 64'd0);

        run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 0);
        check("mul_3x5_model", 64'(model(2'b00, 32'd3, 32'd5)), 64'h0F);
        run_op("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulhsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run_op("mulh_zero", 2'b01, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("bp_7x9", 2'b00, 32'd7, 32'd9, 5);

        // Abort an operation with reset at CALC idx 8.
        @(negedge clk);
        in_valid  = 1'b1;
        op_sel    = 2'b11;
        operand_a = 32'h1234_5678;
        operand_b = 32'h9ABC_DEF0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_state", 64'({in_ready, out_valid, busy}), 64'b100);
        check("abort_result", 64'(result), 64'd0);
        repeat (20) @(negedge clk);
        check("abort_quiet", 64'({out_valid, busy}), 64'b00);
        run_op("post_abort_2x2", 2'b00, 32'd2, 32'd2, 0);
        check("post_abort_val", 64'(result), 64'd4);

        pick[0] = 32'h0000_0000;
        pick[1] = 32'h0000_0001;
        pick[2] = 32'hFFFF_FFFF;
        pick[3] = 32'h8000_0000;
        pick[4] = 32'h7FFF_FFFF;
        for (int n = 0; n < 60; n++) begin
            pick[5] = $urandom;
            ra  = pick[$urandom_range(0, 5)];
            pick[5] = $urandom;
            rb  = pick[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 0) ra = $urandom;
            if ($urandom_range(0, 1) == 0) rb = $urandom;
            rop = 2'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
